instr_fetch_unit: RTL

- Consumes the program counter and turns it into instruction-memory reads.
- Issues one outstanding read at a time over a valid/ready request channel and captures the returned instruction words.
- Buffers fetched words in a small FIFO and presents them, tagged with their PC, to decode over a valid/ready channel.
- A redirect (taken branch or unconditional jump) flushes buffered and in-flight fetches and restarts fetch at the new target.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 91 +++++++++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction size and a saturating counter helper.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } ifu_state_e;

   localparam int unsigned INSTR_BYTES = 4;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush. The head entry is held in a dedicated
// register so the output is registered and keeps its last value when empty.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop_s;

   assign pop_s = pop_i && valid_q;

   // Pointer, occupancy and next-head computation; flush wins over push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      head_d   = head_q;
      if (flush_i) begin
         rd_ptr_d = {AW{1'b0}};
         wr_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
         valid_d  = 1'b0;
      end else begin
         if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_i) - CW'(pop_s);
         valid_d = (count_d != {CW{1'b0}});
         // New head comes straight from the write port when it lands in the head slot.
         if (count_d != {CW{1'b0}}) begin
            head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
         end else begin
            head_d = head_q;
         end
      end
   end

   // Storage array write; contents are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Control and head registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= {AW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         valid_q  <= 1'b0;
         head_q   <= {WIDTH{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   assign valid_o = valid_q;
   assign rdata_o = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, fetched words
// buffered in fetch_fifo and presented to decode tagged with their PC.
// A redirect flushes the buffer and drops any in-flight response.
// Optional build macro IFU_PERF_CNT_EN adds FetchCount/DropCount outputs.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned      PC_W       = 64,
   parameter int unsigned      INSTR_W    = 32,
   parameter int unsigned      FIFO_DEPTH = 4,
   parameter logic [PC_W-1:0]  RESET_PC   = {PC_W{1'b0}}
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Redirect,
   input  logic [PC_W-1:0]     RedirectPC,
   output logic                MemReqValid,
   input  logic                MemReqReady,
   output logic [PC_W-1:0]     MemReqAddr,
   input  logic                MemRespValid,
   input  logic [INSTR_W-1:0]  MemRespData,
   output logic                InstrValid,
   input  logic                InstrReady,
   output logic [INSTR_W-1:0]  InstrData,
   output logic [PC_W-1:0]     InstrPC
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]         FetchCount,
   output logic [31:0]         DropCount
`endif
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OW = CW + 1;
   localparam int unsigned PW = INSTR_W + PC_W;

   ifu_state_e       state_q, state_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  req_pc_q, req_pc_d;
   logic             hs_s, push_s, pop_s, fifo_valid_s;
   logic [CW-1:0]    occ_s;
   logic [OW-1:0]    occ_after_s;
   logic [PW-1:0]    head_s;

   assign hs_s        = (state_q == REQ) && MemReqReady;
   // A response that coincides with a redirect belongs to the old path.
   assign push_s      = (state_q == WAIT) && MemRespValid && !Redirect;
   assign pop_s       = fifo_valid_s && InstrReady;
   assign occ_after_s = OW'(occ_s) + OW'(1'b1) - OW'(pop_s);
   assign req_pc_d    = hs_s ? fetch_pc_q : req_pc_q;

   // Next-state logic; the only outstanding read lives in WAIT or DROP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (Redirect || (occ_s < CW'(FIFO_DEPTH))) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (hs_s) begin
               state_d = Redirect ? DROP : WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (MemRespValid) begin
               if (Redirect || (occ_after_s < OW'(FIFO_DEPTH))) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (Redirect) begin
               state_d = DROP;
            end else begin
               state_d = WAIT;
            end
         end
         DROP: begin
            // A redirect here only moves FetchPC; leave once the stale data is back.
            state_d = MemRespValid ? REQ : DROP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Fetch address: redirect target beats the sequential increment.
   always_comb begin
      if (Redirect) begin
         fetch_pc_d = RedirectPC;
      end else if (hs_s) begin
         fetch_pc_d = fetch_pc_q + PC_W'(INSTR_BYTES);
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
   end

   // FSM state, fetch address and in-flight request PC registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= {PC_W{1'b0}};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PW)
   ) u_fetch_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .flush_i (Redirect),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i ({MemRespData, req_pc_q}),
      .valid_o (fifo_valid_s),
      .rdata_o (head_s),
      .count_o (occ_s)
   );

   assign MemReqValid = (state_q == REQ);
   assign MemReqAddr  = fetch_pc_q;
   assign InstrValid  = fifo_valid_s;
   assign InstrData   = head_s[PW-1:PC_W];
   assign InstrPC     = head_s[PC_W-1:0];

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, drop_cnt_q;
   logic        drop_s;

   assign drop_s = MemRespValid && ((state_q == DROP) || ((state_q == WAIT) && Redirect));

   // Saturating event counters for buffered and discarded responses.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fetch_cnt_q <= 32'd0;
         drop_cnt_q  <= 32'd0;
      end else begin
         if (push_s) begin
            fetch_cnt_q <= sat_inc32(fetch_cnt_q);
         end
         if (drop_s) begin
            drop_cnt_q <= sat_inc32(drop_cnt_q);
         end
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign DropCount  = drop_cnt_q;
`endif

endmodule
